// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multicycle MIPS-subset core: FSM states,
// opcodes, ALUOp codes and datapath mux encodings.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRtypeEx = 4'd6,
    StAluWb   = 4'd7,
    StBeq     = 4'd8,
    StJump    = 4'd9,
    StXoriEx  = 4'd10,
    StXoriWb  = 4'd11
  } state_t;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  // ALUOp, shared with the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_XOR   = 2'b11;

  // ALUSrcB mux
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PCSource mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle core: sequences each instruction,
// decodes datapath controls from the state, counts retired instructions and
// keeps a sticky flag for unsupported opcodes.
module multicycle_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [CNT_W-1:0] retired,
  output logic             illegal_op
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   retired_q;
  logic               illegal_q;
  logic               retire;
  logic               illegal_set;
  logic               pc_write;
  logic               pc_write_cond;

  // Next-state selection plus the retire / illegal-opcode events
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    illegal_set = 1'b0;
    unique case (state_q)
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StRtypeEx;
          OP_BEQ:       state_d = StBeq;
          OP_J:         state_d = StJump;
          OP_XORI:      state_d = StXoriEx;
          default: begin
            state_d     = StFetch;
            illegal_set = 1'b1;
          end
        endcase
      end
      // Only lw/sw reach here and the IR is stable, so anything not sw is lw
      StMemAdr:  state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StRtypeEx: state_d = StAluWb;
      StXoriEx:  state_d = StXoriWb;
      StAluWb, StBeq, StJump, StXoriWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default:   state_d = StFetch;
    endcase
  end

  // Datapath control decode; reset overrides everything to the idle values
  always_comb begin
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_REGB;
    PCSource      = PCSRC_ALU;
    ALUOp         = ALUOP_ADD;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    unique case (state_q)
      StFetch: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        IRWrite  = mem_ready;
        pc_write = mem_ready;
      end
      StDecode:  ALUSrcB = SRCB_IMMSH;
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      StMemRd: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      StMemWb: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      StMemWr: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      StRtypeEx: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      StAluWb: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      StBeq: begin
        ALUSrcA       = 1'b1;
        ALUOp         = ALUOP_SUB;
        pc_write_cond = 1'b1;
        PCSource      = PCSRC_ALUOUT;
      end
      StJump: begin
        pc_write = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      StXoriEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_XOR;
      end
      StXoriWb:  RegWrite = 1'b1;
      default: ;
    endcase
    pc_en = pc_write | (pc_write_cond & zero);
    if (reset) begin
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      MemtoReg = 1'b0;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = SRCB_REGB;
      PCSource = PCSRC_ALU;
      ALUOp    = ALUOP_ADD;
      pc_en    = 1'b0;
    end
  end

  // State register, retired counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)      retired_q <= retired_q + CNT_W'(1);
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  assign retired    = retired_q;
  assign illegal_op = illegal_q;

endmodule
